hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and works alongside the forwarding controller. It resolves the hazards forwarding cannot cover: load-use dependencies, taken-branch redirects and multi-cycle data-memory accesses. It also keeps a memory-wait watchdog and saturating performance counters.

---
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer for the 5-stage core: memory freeze, branch flush,
// load-use bubble, memory-wait watchdog and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int PERF_CNT_W  = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_instr_opcode_ip,
  input  logic [4:0]            ID_rs1_ip,
  input  logic [4:0]            ID_rs2_ip,
  input  logic [4:0]            ID_EX_dest_ip,
  input  logic                  ID_EX_mem_read_ip,
  input  logic                  EX_branch_taken_ip,
  input  logic                  dmem_req_ip,
  input  logic                  dmem_gnt_ip,
  input  logic                  perf_clr_ip,
  output logic                  pc_stall_op,
  output logic                  if_id_stall_op,
  output logic                  if_id_flush_op,
  output logic                  id_ex_stall_op,
  output logic                  id_ex_bubble_op,
  output logic                  ex_mem_stall_op,
  output logic                  mem_wb_bubble_op,
  output logic                  state_op,
  output logic                  mem_timeout_op,
  output logic [PERF_CNT_W-1:0] stall_cycles_op,
  output logic [PERF_CNT_W-1:0] flush_count_op
);

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic [7:0]            WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [PERF_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [PERF_CNT_W-1:0] CNT_ONE    = PERF_CNT_W'(1);

  logic       uses_rs1;
  logic       uses_rs2;
  logic       freeze;
  logic       loaduse;
  logic       branch_act;
  logic       loaduse_act;
  logic [1:0] cnt_inc;

  logic [0:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instr_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  assign freeze  = dmem_req_ip & ~dmem_gnt_ip;
  assign loaduse = ID_EX_mem_read_ip & (ID_EX_dest_ip != 5'd0) &
                   ((uses_rs1 & (ID_rs1_ip == ID_EX_dest_ip)) |
                    (uses_rs2 & (ID_rs2_ip == ID_EX_dest_ip)));

  // Freeze dominates; a branch held during a freeze is acted on once it releases.
  assign branch_act  = EX_branch_taken_ip & ~freeze;
  assign loaduse_act = loaduse & ~freeze & ~EX_branch_taken_ip;

  // Controls are gated by reset so an asserted reset kills any stall at once.
  assign pc_stall_op      = reset & (freeze | loaduse_act);
  assign if_id_stall_op   = reset & (freeze | loaduse_act);
  assign if_id_flush_op   = reset & branch_act;
  assign id_ex_stall_op   = reset & freeze;
  assign id_ex_bubble_op  = reset & (branch_act | loaduse_act);
  assign ex_mem_stall_op  = reset & freeze;
  assign mem_wb_bubble_op = reset & freeze;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (freeze)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!freeze) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (perf_clr_ip) begin
      timeout_d = 1'b0;
    end else if (freeze && (wait_cnt_q == WAIT_LIMIT)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Counter 0 tracks stall cycles, counter 1 tracks branch-flush cycles.
  assign cnt_inc[0] = freeze | loaduse_act;
  assign cnt_inc[1] = branch_act;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (perf_clr_ip) begin
          cnt_d = '0;
        end else if (cnt_inc[gi] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign stall_cycles_op = g_cnt[0].cnt_q;
  assign flush_count_op  = g_cnt[1].cnt_q;
  assign state_op        = state_q;
  assign mem_timeout_op  = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, directed corner sequences and random
// stimulus against a rule-level reference model; a 4-bit instance covers saturation.
module tb_hazard_stall_ctrl;

  localparam int MT = 4;
  localparam int SAT_MAX = 15;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_OPIMM = 7'b0010011, O_STORE = 7'b0100011,
                         O_OP = 7'b0110011, O_BRANCH = 7'b1100011, O_JALR = 7'b1100111,
                         O_LUI = 7'b0110111, O_JAL = 7'b1101111;

  typedef struct {
    logic [6:0] opc;
    logic [4:0] rs1, rs2, dest;
    logic       memrd, br, req, gnt, clr;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opc_i = '0;
  logic [4:0] rs1_i = '0, rs2_i = '0, dest_i = '0;
  logic memrd_i = 1'b0, br_i = 1'b0, req_i = 1'b0, gnt_i = 1'b0, clr_i = 1'b0;

  logic pc_st, ifid_st, ifid_fl, idex_st, idex_bb, exmem_st, memwb_bb, st, to;
  logic [31:0] stall_c, flush_c;
  logic s_pc_st, s_ifid_st, s_ifid_fl, s_idex_st, s_idex_bb, s_exmem_st, s_memwb_bb, s_st, s_to;
  logic [3:0] s_stall_c, s_flush_c;

  int n_checks = 0;
  int n_fail = 0;

  int m_stall, m_flush, m_sat_stall, m_sat_flush, m_run;
  bit m_to, m_state;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.PERF_CNT_W(32), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .id_instr_opcode_ip(opc_i), .ID_rs1_ip(rs1_i),
    .ID_rs2_ip(rs2_i), .ID_EX_dest_ip(dest_i), .ID_EX_mem_read_ip(memrd_i),
    .EX_branch_taken_ip(br_i), .dmem_req_ip(req_i), .dmem_gnt_ip(gnt_i),
    .perf_clr_ip(clr_i), .pc_stall_op(pc_st), .if_id_stall_op(ifid_st),
    .if_id_flush_op(ifid_fl), .id_ex_stall_op(idex_st), .id_ex_bubble_op(idex_bb),
    .ex_mem_stall_op(exmem_st), .mem_wb_bubble_op(memwb_bb), .state_op(st),
    .mem_timeout_op(to), .stall_cycles_op(stall_c), .flush_count_op(flush_c)
  );

  hazard_stall_ctrl #(.PERF_CNT_W(4), .MEM_TIMEOUT(64)) dut_sat (
    .clk(clk), .reset(reset), .id_instr_opcode_ip(opc_i), .ID_rs1_ip(rs1_i),
    .ID_rs2_ip(rs2_i), .ID_EX_dest_ip(dest_i), .ID_EX_mem_read_ip(memrd_i),
    .EX_branch_taken_ip(br_i), .dmem_req_ip(req_i), .dmem_gnt_ip(gnt_i),
    .perf_clr_ip(clr_i), .pc_stall_op(s_pc_st), .if_id_stall_op(s_ifid_st),
    .if_id_flush_op(s_ifid_fl), .id_ex_stall_op(s_idex_st), .id_ex_bubble_op(s_idex_bb),
    .ex_mem_stall_op(s_exmem_st), .mem_wb_bubble_op(s_memwb_bb), .state_op(s_st),
    .mem_timeout_op(s_to), .stall_cycles_op(s_stall_c), .flush_count_op(s_flush_c)
  );

  wire [6:0] ctrl_got = {pc_st, ifid_st, ifid_fl, idex_st, idex_bb, exmem_st, memwb_bb};
  wire [6:0] s_ctrl_got = {s_pc_st, s_ifid_st, s_ifid_fl, s_idex_st, s_idex_bb, s_exmem_st, s_memwb_bb};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [6:0] opc, input int rs1, input int rs2, input int dest,
                               input bit memrd, input bit br, input bit req, input bit gnt, input bit clr);
    stim_t s;
    s.opc = opc; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.dest = 5'(dest);
    s.memrd = memrd; s.br = br; s.req = req; s.gnt = gnt; s.clr = clr;
    return s;
  endfunction

  // Which architectural hazard, if any, the pipeline must respond to this cycle.
  function automatic bit is_freeze(input stim_t s);
    return s.req && !s.gnt;
  endfunction

  function automatic bit has_loaduse(input stim_t s);
    bit r1, r2;
    r1 = (s.opc == O_OP || s.opc == O_STORE || s.opc == O_BRANCH ||
          s.opc == O_OPIMM || s.opc == O_LOAD || s.opc == O_JALR);
    r2 = (s.opc == O_OP || s.opc == O_STORE || s.opc == O_BRANCH);
    if (!s.memrd || s.dest == 0) return 0;
    return (r1 && s.rs1 == s.dest) || (r2 && s.rs2 == s.dest);
  endfunction

  // Expected {pc, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble}.
  function automatic logic [6:0] exp_ctrl(input stim_t s);
    if (is_freeze(s)) return 7'b1101011;
    if (s.br) return 7'b0010100;
    if (has_loaduse(s)) return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic int sat_add(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_sat_stall = 0; m_sat_flush = 0;
    m_run = 0; m_to = 0; m_state = 0;
  endtask

  task automatic model_edge(input stim_t s);
    bit stall_evt, flush_evt;
    stall_evt = is_freeze(s) || (!s.br && has_loaduse(s));
    flush_evt = !is_freeze(s) && s.br;
    m_run   = is_freeze(s) ? m_run + 1 : 0;
    m_state = is_freeze(s);
    if (s.clr) begin
      m_stall = 0; m_flush = 0; m_sat_stall = 0; m_sat_flush = 0; m_to = 0;
    end else begin
      if (stall_evt) begin
        m_stall = m_stall + 1;
        m_sat_stall = sat_add(m_sat_stall, SAT_MAX);
      end
      if (flush_evt) begin
        m_flush = m_flush + 1;
        m_sat_flush = sat_add(m_sat_flush, SAT_MAX);
      end
      if (m_run == MT) m_to = 1;
    end
  endtask

  task automatic drive(input stim_t s);
    opc_i = s.opc; rs1_i = s.rs1; rs2_i = s.rs2; dest_i = s.dest;
    memrd_i = s.memrd; br_i = s.br; req_i = s.req; gnt_i = s.gnt; clr_i = s.clr;
  endtask

  // One transaction: called at posedge+1, returns at the following posedge+1.
  task automatic cycle(input string tag, input stim_t s);
    drive(s);
    #1;
    chk({tag, "_ctrl"}, 64'(ctrl_got), 64'(exp_ctrl(s)));
    chk({tag, "_sat_ctrl"}, 64'(s_ctrl_got), 64'(exp_ctrl(s)));
    @(posedge clk);
    model_edge(s);
    #1;
    chk({tag, "_state"}, 64'(st), 64'(m_state));
    chk({tag, "_timeout"}, 64'(to), 64'(m_to));
    chk({tag, "_stall_cnt"}, 64'(stall_c), 64'(m_stall));
    chk({tag, "_flush_cnt"}, 64'(flush_c), 64'(m_flush));
    chk({tag, "_sat_stall"}, 64'(s_stall_c), 64'(m_sat_stall));
    chk({tag, "_sat_flush"}, 64'(s_flush_c), 64'(m_sat_flush));
    $display("%s opc=%h rs1=%0d rs2=%0d rd=%0d ld=%b br=%b req=%b gnt=%b clr=%b ctrl=%b st=%b to=%b stall=%0d flush=%0d",
             tag, s.opc, s.rs1, s.rs2, s.dest, s.memrd, s.br, s.req, s.gnt, s.clr,
             ctrl_got, st, to, stall_c, flush_c);
  endtask

  vec_t vecs[13];
  logic [6:0] opcs[8];
  stim_t idle, clr, frz, s;

  initial begin
    idle = mk(O_OP, 0, 0, 0, 0, 0, 0, 0, 0);
    clr  = mk(O_OP, 0, 0, 0, 0, 0, 0, 0, 1);
    frz  = mk(O_OP, 1, 2, 2, 1, 0, 1, 0, 0);
    opcs = '{O_OP, O_STORE, O_BRANCH, O_OPIMM, O_LOAD, O_JALR, O_LUI, O_JAL};

    vecs[0]  = '{mk(O_OP,     1, 2, 2, 1, 0, 0, 0, 0), 7'b1100100};
    vecs[1]  = '{mk(O_OP,     0, 0, 0, 1, 0, 0, 0, 0), 7'b0000000};
    vecs[2]  = '{mk(O_LUI,    5, 5, 5, 1, 0, 0, 0, 0), 7'b0000000};
    vecs[3]  = '{mk(O_OP,     1, 2, 2, 1, 1, 0, 0, 0), 7'b0010100};
    vecs[4]  = '{mk(O_OP,     0, 0, 0, 0, 0, 1, 0, 0), 7'b1101011};
    vecs[5]  = '{mk(O_OP,     3, 1, 3, 1, 0, 1, 1, 0), 7'b1100100};
    vecs[6]  = '{mk(O_STORE,  4, 7, 7, 1, 0, 0, 0, 0), 7'b1100100};
    vecs[7]  = '{mk(O_OPIMM,  4, 7, 7, 1, 0, 0, 0, 0), 7'b0000000};
    vecs[8]  = '{mk(O_JALR,   9, 0, 9, 1, 0, 0, 0, 0), 7'b1100100};
    vecs[9]  = '{mk(O_BRANCH, 1, 6, 6, 1, 0, 0, 0, 0), 7'b1100100};
    vecs[10] = '{mk(O_OP,     1, 2, 2, 1, 1, 1, 0, 0), 7'b1101011};
    vecs[11] = '{mk(O_OP,     1, 2, 2, 0, 0, 0, 0, 0), 7'b0000000};
    vecs[12] = '{mk(O_JAL,    8, 8, 8, 1, 0, 0, 0, 0), 7'b0000000};

    // Reset held with hazardous inputs: controls and state must stay quiet.
    model_reset();
    drive(frz);
    #12;
    chk("rst_ctrl", 64'(ctrl_got), 64'd0);
    chk("rst_state", 64'(st), 64'd0);
    chk("rst_timeout", 64'(to), 64'd0);
    chk("rst_stall_cnt", 64'(stall_c), 64'd0);
    chk("rst_flush_cnt", 64'(flush_c), 64'd0);
    drive(idle);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].s);
      #1;
      chk($sformatf("vec%0d_table", i), 64'(ctrl_got), 64'(vecs[i].exp));
      cycle($sformatf("vec%0d", i), vecs[i].s);
    end

    // Load-use inserts exactly one bubble, then the load has left EX.
    cycle("A_clr", clr);
    cycle("A_lu", mk(O_OP, 1, 2, 2, 1, 0, 0, 0, 0));
    cycle("A_next", mk(O_OP, 1, 2, 0, 0, 0, 0, 0, 0));
    chk("A_stall_total", 64'(stall_c), 64'd1);
    chk("A_flush_total", 64'(flush_c), 64'd0);

    // Three freeze cycles with a branch held, then gnt releases into the flush.
    cycle("B_clr", clr);
    cycle("B_f1", mk(O_OP, 0, 0, 0, 0, 1, 1, 0, 0));
    chk("B_state_wait", 64'(st), 64'd1);
    cycle("B_f2", mk(O_OP, 0, 0, 0, 0, 1, 1, 0, 0));
    cycle("B_f3", mk(O_OP, 0, 0, 0, 0, 1, 1, 0, 0));
    cycle("B_gnt", mk(O_OP, 0, 0, 0, 0, 1, 1, 1, 0));
    chk("B_state_run", 64'(st), 64'd0);
    chk("B_stall_total", 64'(stall_c), 64'd3);
    chk("B_flush_total", 64'(flush_c), 64'd1);

    // Watchdog: flag after the 4th freeze cycle, sticky through gnt, cleared by perf_clr.
    cycle("C_clr", clr);
    for (int i = 1; i <= 4; i++) begin
      cycle($sformatf("C_f%0d", i), mk(O_OP, 0, 0, 0, 0, 0, 1, 0, 0));
      chk($sformatf("C_to_after%0d", i), 64'(to), (i == 4) ? 64'd1 : 64'd0);
    end
    cycle("C_gnt", mk(O_OP, 0, 0, 0, 0, 0, 1, 1, 0));
    chk("C_to_sticky", 64'(to), 64'd1);
    chk("C_stall_total", 64'(stall_c), 64'd4);
    cycle("C_clr2", clr);
    chk("C_to_cleared", 64'(to), 64'd0);
    chk("C_stall_cleared", 64'(stall_c), 64'd0);
    chk("C_flush_cleared", 64'(flush_c), 64'd0);

    // Asynchronous reset in the middle of a freeze.
    cycle("D_f1", frz);
    cycle("D_f2", frz);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("D_ctrl_async", 64'(ctrl_got), 64'd0);
    chk("D_state_async", 64'(st), 64'd0);
    chk("D_stall_async", 64'(stall_c), 64'd0);
    @(posedge clk);
    #1;
    chk("D_ctrl_held", 64'(ctrl_got), 64'd0);
    chk("D_state_held", 64'(st), 64'd0);
    drive(idle);
    #2 reset = 1'b1;
    @(posedge clk);
    model_edge(idle);
    #1;
    chk("D_state_after", 64'(st), 64'd0);
    chk("D_stall_after", 64'(stall_c), 64'd0);
    chk("D_flush_after", 64'(flush_c), 64'd0);

    // 4-bit counters saturate at 15.
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("E_lu%0d", i), mk(O_OPIMM, 3, 0, 3, 1, 0, 0, 0, 0));
    end
    for (int i = 0; i < 18; i++) begin
      cycle($sformatf("E_br%0d", i), mk(O_OP, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    chk("E_sat_stall", 64'(s_stall_c), 64'd15);
    chk("E_sat_flush", 64'(s_flush_c), 64'd15);
    chk("E_wide_stall", 64'(stall_c), 64'd20);

    for (int i = 0; i < 600; i++) begin
      s.opc   = opcs[$urandom_range(0, 7)];
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.dest  = 5'($urandom_range(0, 3));
      s.memrd = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 3) == 0);
      s.req   = ($urandom_range(0, 2) != 0);
      s.gnt   = ($urandom_range(0, 3) == 0);
      s.clr   = ($urandom_range(0, 31) == 0);
      cycle($sformatf("R%0d", i), s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
